// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: sequences loads, word stores and
// byte/half read-modify-write stores against a single-port-style word RAM.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       rdata_q;
    logic              mis_q;

    logic              mis_in;
    logic              accept;
    logic [31:0]       rd_shift;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // Address bits above the RAM index are discarded, so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:ADDR_W+2];

    assign accept = (state_q == StIdle) && req_i;
    assign mis_in = ((size_i == 2'b01) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (mis_in)         state_d = StResp;
                    else if (!we_i)     state_d = StLoad;
                    else if (size_i[1]) state_d = StWrite;
                    else                state_d = StRmwRd;
                end
            end
            StLoad:  state_d = StResp;
            StRmwRd: state_d = StWrite;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register plus latched request, RMW old word and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                sign_q  <= sign_i;
                addr_q  <= addr_i[ADDR_W+1:0];
                wdata_q <= wdata_i;
                mis_q   <= mis_in;
                if (mis_in) rdata_q <= '0;
            end
            if (state_q == StLoad)  rdata_q <= load_ext;
            if (state_q == StRmwRd) old_q   <= ram_rdata_i;
        end
    end

    // Load lane extraction; a half is 2-byte aligned so the same byte shift serves both.
    always_comb begin
        rd_shift = ram_rdata_i >> {addr_q[1:0], 3'b000};
        load_ext = ram_rdata_i;
        unique case (size_q)
            2'b00:   load_ext = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = ram_rdata_i;
        endcase
    end

    // Old word with only the addressed lanes replaced by store data.
    always_comb begin
        merged = old_q;
        if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // RAM strobes and handshake outputs decoded from state and latched request.
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        ram_wdata_o = '0;
        done_o      = 1'b0;
        misalign_o  = 1'b0;
        unique case (state_q)
            StLoad, StRmwRd: begin
                ram_ce_o = 1'b1;
                ram_re_o = 1'b1;
            end
            StWrite: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_wdata_o = (size_q[1] || !we_q) ? wdata_q : merged;
            end
            StResp: begin
                done_o     = 1'b1;
                misalign_o = mis_q;
            end
            default: ;
        endcase
    end

    assign ram_waddr_o = (state_q != StIdle) ? addr_q[ADDR_W+1:2] : '0;
    assign ram_raddr_o = (state_q != StIdle) ? addr_q[ADDR_W+1:2] : '0;
    assign rdata_o     = rdata_q;
    assign stall_o     = accept || (state_q == StLoad) || (state_q == StRmwRd) ||
                         (state_q == StWrite);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small RAM model and a done_o-driven scoreboard.
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_i = 1'b0;
    logic              we_i = 1'b0;
    logic [1:0]        size_i = 2'b00;
    logic              sign_i = 1'b0;
    logic [31:0]       addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic [31:0]       rdata_o;
    logic              done_o;
    logic              stall_o;
    logic              misalign_o;
    logic              ram_ce_o;
    logic              ram_we_o;
    logic              ram_re_o;
    logic [ADDR_W-1:0] ram_waddr_o;
    logic [ADDR_W-1:0] ram_raddr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .sign_i      (sign_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .ram_ce_o    (ram_ce_o),
        .ram_we_o    (ram_we_o),
        .ram_re_o    (ram_re_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge.
    logic [31:0] mem [0:255] = '{default: 32'h0};
    assign ram_rdata_i = mem[ram_raddr_o[7:0]];
    always @(posedge clk) if (ram_ce_o && ram_we_o) mem[ram_waddr_o[7:0]] <= ram_wdata_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int   n_vec = 0;
    int   n_err = 0;
    logic no_ram = 1'b0;
    logic chk_stall = 1'b0;
    int   we_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each done_o.
    always @(negedge clk) begin
        exp_t e;
        check("re_we_exclusive", {31'b0, ram_re_o & ram_we_o}, 32'h0);
        if (no_ram) check("misalign_no_ce", {31'b0, ram_ce_o}, 32'h0);
        if (ram_we_o) we_seen++;
        if (chk_stall) check("stall_vs_resp", {31'b0, stall_o}, {31'b0, !done_o});
        if (done_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 expected none at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check("rdata", rdata_o, e.rd);
                check("misalign", {31'b0, misalign_o}, {31'b0, e.mis});
                check("done_latency", cyc, e.cyc);
            end
        end
    end

    // Issue one request from an IDLE negedge, scramble inputs after accept, wait for done_o.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_mis, input int lat);
        exp_t e;
        int   n;
        req_i   = 1'b1;
        we_i    = we;
        size_i  = size;
        sign_i  = sgn;
        addr_i  = addr;
        wdata_i = wdata;
        e.rd    = exp_rd;
        e.mis   = exp_mis;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        we_i    = ~we;
        size_i  = ~size;
        sign_i  = ~sgn;
        addr_i  = $urandom;
        wdata_i = $urandom;
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done_o expected one within 20 cycles");
        end
        req_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   nd;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   nd;
        repeat (3) @(negedge clk);
        check("rst_done", {31'b0, done_o}, 32'h0);
        check("rst_misalign", {31'b0, misalign_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_enables", {29'b0, ram_ce_o, ram_we_o, ram_re_o}, 32'h0);
        check("rst_waddr", {15'b0, ram_waddr_o}, 32'h0);
        check("rst_raddr", {15'b0, ram_raddr_o}, 32'h0);
        check("rst_wdata", ram_wdata_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0, 2);
        check("mem_sw", mem[8'h40], 32'h11223344);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h11223344, 1'b0, 2);
        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hAB, 32'h11223344, 1'b0, 3);
        check("mem_sb", mem[8'h40], 32'h1122AB44);
        do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'hFFFFFF81, 32'h11223344, 1'b0, 3);
        check("mem_sb_hi", mem[8'h40], 32'h8122AB44);

        do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
        do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h000000AB, 1'b0, 2);
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hFFFF8122, 1'b0, 2);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h00008122, 1'b0, 2);
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'hFFFFAB44, 1'b0, 2);
        do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h00000044, 1'b0, 2);

        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h12345566, 32'h00000044, 1'b0, 3);
        check("mem_sh", mem[8'h40], 32'h5566AB44);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h5566AB44, 1'b0, 2);

        no_ram = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
        do_req(1'b1, 2'b01, 1'b0, 32'h103, 32'hCAFE, 32'h0, 1'b1, 1);
        no_ram = 1'b0;
        check("mem_misalign", mem[8'h40], 32'h5566AB44);

        // Bit 19 lies above the word index, so this lands on index 0x40.
        do_req(1'b1, 2'b10, 1'b0, 32'h00080100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("mem_wrap", mem[8'h40], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Reset during the RMW read of a byte store.
        we_seen = 0;
        req_i   = 1'b1;
        we_i    = 1'b1;
        size_i  = 2'b00;
        sign_i  = 1'b0;
        addr_i  = 32'h100;
        wdata_i = 32'h77;
        @(negedge clk);
        check("rmw_rd_re", {31'b0, ram_re_o}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_re", {31'b0, ram_re_o}, 32'h0);
        check("abort_ce", {31'b0, ram_ce_o}, 32'h0);
        check("abort_done", {31'b0, done_o}, 32'h0);
        req_i = 1'b0;
        #1;
        check("abort_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_we", we_seen, 32'h0);
        check("abort_mem", mem[8'h40], 32'hDEADBEEF);
        check("abort_rdata", rdata_o, 32'h0);

        do_req(1'b1, 2'b11, 1'b0, 32'h104, 32'h0BADF00D, 32'h0, 1'b0, 2);
        check("mem_size3", mem[8'h41], 32'h0BADF00D);
        do_req(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 1'b0, 2);

        // Three back-to-back loads with req_i held throughout.
        req_i   = 1'b1;
        we_i    = 1'b0;
        size_i  = 2'b10;
        sign_i  = 1'b0;
        addr_i  = 32'h100;
        wdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            e.rd  = 32'hDEADBEEF;
            e.mis = 1'b0;
            e.cyc = cyc + 2 + 3 * i;
            sb.push_back(e);
        end
        chk_stall = 1'b1;
        nd = 0;
        n  = 0;
        while (nd < 3 && n < 30) begin
            @(negedge clk);
            n++;
            if (done_o) nd++;
        end
        req_i     = 1'b0;
        chk_stall = 1'b0;
        check("b2b_done_count", nd, 32'd3);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
